ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 SHALL have parameter OPC_W, default 3, opcode width (3..5).
REQ-002 SHALL have parameter MAX_WAIT, default 15, max stall cycles per memory phase (1..255).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- opcode  input  OPC_W  current instruction opcode.
- zero  input  1  accumulator-zero flag.
- mem_ready  input  1  memory ready for the current rd/wr phase.
- resume  input  1  one-cycle request to leave HALTED.
- phase  output  3  current phase count.
- sel, rd, ld_ir, inc_pc, halt, ld_ac, data_e, ld_pc, wr  output  1 each  datapath strobes.
- fault  output  1  sticky fault flag.
- err_code  output  2  00 none, 01 bus timeout, 10 illegal opcode.

Function
REQ-005 SHALL own a registered 3-bit phase counter and a state register with states RUN, HALTED, FAULT.
REQ-006 Opcode classes: HLT=0, SKZ=1, ALU=2..5, STO=6, JMP=7; values above 7 (OPC_W>3) SHALL be illegal.
REQ-007 In RUN, strobes SHALL decode combinationally from phase and opcode:
- ph0: sel.
- ph1: sel, rd.
- ph2, ph3: sel, rd, ld_ir.
- ph4: inc_pc; halt if HLT.
- ph5: rd if ALU.
- ph6: rd if ALU; inc_pc if SKZ and zero; ld_pc if JMP; data_e if STO.
- ph7: rd if ALU; ld_pc if JMP; data_e and wr if STO; ld_ac if ALU.
REQ-008 A phase with rd or wr asserted is a memory phase; phase SHALL advance only in a cycle where mem_ready=1; all other phases SHALL advance every cycle.
REQ-009 ld_ir and ld_ac SHALL be gated by mem_ready so each loads exactly once per instruction despite stalls; other strobes SHALL hold steady while stalled.
REQ-010 Phase SHALL wrap 7->0 with no bubble.
REQ-011 Stall counter SHALL clear on every phase advance; if it reaches MAX_WAIT without mem_ready, next state SHALL be FAULT with err_code=01.
REQ-012 In ph4, HLT opcode SHALL move to HALTED with phase frozen at 4; inc_pc SHALL fire once in the ph4 cycle only.
REQ-013 In ph4, an illegal opcode SHALL move to FAULT with err_code=10; inc_pc still fires in that cycle.
REQ-014 HALTED: halt=1, all other strobes 0; resume=1 SHALL return to RUN with phase=5 next cycle.
REQ-015 FAULT: halt=1, all other strobes 0, fault=1, err_code held; resume ignored; only rst exits.
REQ-016 mem_ready in non-memory phases and resume outside HALTED SHALL be ignored.
REQ-017 Simultaneous timeout and mem_ready in the same cycle: mem_ready wins (advance, no fault).

Reset
REQ-018 rst SHALL override all inputs including resume, in any state, mid-stall included.
REQ-019 During and after reset: phase=0, state=RUN, stall counter=0, fault=0, err_code=00; outputs sel=1, all other strobes 0.

Structure
REQ-020 Package ctrl_pkg SHALL hold opcode constants, phase constants, state encoding, err_code values.
REQ-021 Stall counter SHALL be sub-module wait_timer (inputs clear, enable; output expired; parameter MAX_WAIT).

Verification
REQ-022 ADD (opcode=2), mem_ready tied 1 -> phases 0..7 in 8 cycles, ld_ir high ph2 and ph3, ld_ac high ph7 only, inc_pc ph4 only.
REQ-023 STO (6), mem_ready low 3 cycles in ph7 -> phase holds 3 cycles with wr=1, advances to 0 on 4th cycle.
REQ-024 HLT (0) -> halt=1 from ph4, phase stays 4 for 10 cycles, single inc_pc; resume pulse -> phase=5 next cycle.
REQ-025 MAX_WAIT=4, mem_ready low in ph1 -> FAULT after 4 stall cycles, err_code=01, resume ignored, rst clears.
REQ-026 SKZ (1) with zero=1 -> inc_pc in ph4 and ph6; zero=0 -> ph4 only.
REQ-027 OPC_W=4, opcode=9 -> FAULT at ph4 with err_code=10; rst mid-stall in ph2 -> phase=0, sel=1 next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode, phase, state and error encodings for the instruction sequencer.
package ctrl_pkg;

   localparam logic [2:0] OPC_HLT    = 3'd0;
   localparam logic [2:0] OPC_SKZ    = 3'd1;
   localparam logic [2:0] OPC_ALU_LO = 3'd2;
   localparam logic [2:0] OPC_ALU_HI = 3'd5;
   localparam logic [2:0] OPC_STO    = 3'd6;
   localparam logic [2:0] OPC_JMP    = 3'd7;

   localparam logic [2:0] PH_0 = 3'd0;
   localparam logic [2:0] PH_1 = 3'd1;
   localparam logic [2:0] PH_2 = 3'd2;
   localparam logic [2:0] PH_3 = 3'd3;
   localparam logic [2:0] PH_4 = 3'd4;
   localparam logic [2:0] PH_5 = 3'd5;
   localparam logic [2:0] PH_6 = 3'd6;
   localparam logic [2:0] PH_7 = 3'd7;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_HALTED = 2'b01,
      ST_FAULT  = 2'b10
   } state_t;

   typedef enum logic [2:0] {
      CLS_HLT = 3'd0,
      CLS_SKZ = 3'd1,
      CLS_ALU = 3'd2,
      CLS_STO = 3'd3,
      CLS_JMP = 3'd4,
      CLS_ILL = 3'd5
   } opc_class_t;

   typedef struct packed {
      logic sel;
      logic rd;
      logic ld_ir;
      logic inc_pc;
      logic halt;
      logic ld_ac;
      logic data_e;
      logic ld_pc;
      logic wr;
   } strobes_t;

   // Opcodes are zero-extended to 8 bits; any set bit above bit 2 is illegal.
   function automatic opc_class_t classify(input logic [7:0] opc);
      opc_class_t cls;
      if (opc[7:3] != 5'd0) begin
         cls = CLS_ILL;
      end else if (opc[2:0] == OPC_HLT) begin
         cls = CLS_HLT;
      end else if (opc[2:0] == OPC_SKZ) begin
         cls = CLS_SKZ;
      end else if (opc[2:0] >= OPC_ALU_LO && opc[2:0] <= OPC_ALU_HI) begin
         cls = CLS_ALU;
      end else if (opc[2:0] == OPC_STO) begin
         cls = CLS_STO;
      end else if (opc[2:0] == OPC_JMP) begin
         cls = CLS_JMP;
      end else begin
         cls = CLS_ILL;
      end
      return cls;
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive stall cycles of one memory phase and flags the last allowed one.
module wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // count_r holds the number of stall cycles already spent, so the current one is count_r+1.
   localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

   logic [7:0] count_r;

   // Stall counter: clear has priority, saturates at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= 8'd0;
      end else if (clear) begin
         count_r <= 8'd0;
      end else if (enable && (count_r < LIMIT)) begin
         count_r <= count_r + 8'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // High when the present stall cycle is the MAX_WAIT-th one.
   always_comb begin
      expired = 1'b0;
      if (count_r >= LIMIT) begin
         expired = 1'b1;
      end else begin
         expired = 1'b0;
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Eight-phase instruction sequencer: decodes datapath strobes from phase and opcode,
// stretches memory phases on mem_ready, and traps halts, bus timeouts and illegal opcodes.
module ctrl_sequencer #(
   parameter int OPC_W    = 3,
   parameter int MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             resume,
   output logic [2:0]       phase,
   output logic             sel,
   output logic             rd,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             halt,
   output logic             ld_ac,
   output logic             data_e,
   output logic             ld_pc,
   output logic             wr,
   output logic             fault,
   output logic [1:0]       err_code
);

   import ctrl_pkg::*;

   state_t     state_r;
   logic [2:0] phase_r;
   logic       fault_r;
   logic [1:0] err_r;

   opc_class_t cls_s;
   strobes_t   run_s;
   strobes_t   out_s;
   logic       mem_phase_s;
   logic       advance_s;
   logic       stall_s;
   logic       timer_clear_s;
   logic       expired_s;

   assign cls_s = classify(8'(opcode));

   // RUN-state strobe decode; ld_ir/ld_ac wait for mem_ready so they load once per instruction.
   always_comb begin
      run_s = strobes_t'(9'd0);
      case (phase_r)
         PH_0: begin
            run_s.sel = 1'b1;
         end
         PH_1: begin
            run_s.sel = 1'b1;
            run_s.rd  = 1'b1;
         end
         PH_2, PH_3: begin
            run_s.sel   = 1'b1;
            run_s.rd    = 1'b1;
            run_s.ld_ir = mem_ready;
         end
         PH_4: begin
            run_s.inc_pc = 1'b1;
            run_s.halt   = (cls_s == CLS_HLT);
         end
         PH_5: begin
            run_s.rd = (cls_s == CLS_ALU);
         end
         PH_6: begin
            run_s.rd     = (cls_s == CLS_ALU);
            run_s.inc_pc = (cls_s == CLS_SKZ) && zero;
            run_s.ld_pc  = (cls_s == CLS_JMP);
            run_s.data_e = (cls_s == CLS_STO);
         end
         PH_7: begin
            run_s.rd     = (cls_s == CLS_ALU);
            run_s.ld_pc  = (cls_s == CLS_JMP);
            run_s.data_e = (cls_s == CLS_STO);
            run_s.wr     = (cls_s == CLS_STO);
            run_s.ld_ac  = (cls_s == CLS_ALU) && mem_ready;
         end
         default: begin
            run_s = strobes_t'(9'd0);
         end
      endcase
   end

   assign mem_phase_s   = run_s.rd | run_s.wr;
   assign advance_s     = ~mem_phase_s | mem_ready;
   assign stall_s       = (state_r == ST_RUN) & mem_phase_s & ~mem_ready;
   assign timer_clear_s = (state_r != ST_RUN) | advance_s;

   wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear_s),
      .enable  (stall_s),
      .expired (expired_s)
   );

   // Output strobe selection by state; reset forces the phase-0 pattern immediately.
   always_comb begin
      out_s = strobes_t'(9'd0);
      if (rst) begin
         out_s.sel = 1'b1;
      end else begin
         case (state_r)
            ST_RUN: begin
               out_s = run_s;
            end
            ST_HALTED: begin
               out_s.halt = 1'b1;
            end
            ST_FAULT: begin
               out_s.halt = 1'b1;
            end
            default: begin
               out_s.halt = 1'b1;
            end
         endcase
      end
   end

   // Sequencer FSM: phase advance, halt/resume and sticky fault capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_RUN;
         phase_r <= PH_0;
         fault_r <= 1'b0;
         err_r   <= ERR_NONE;
      end else begin
         case (state_r)
            ST_RUN: begin
               if ((phase_r == PH_4) && (cls_s == CLS_ILL)) begin
                  state_r <= ST_FAULT;
                  fault_r <= 1'b1;
                  err_r   <= ERR_ILLEGAL;
               end else if ((phase_r == PH_4) && (cls_s == CLS_HLT)) begin
                  state_r <= ST_HALTED;
               end else if (stall_s && expired_s) begin
                  // A late mem_ready clears stall_s, so it always beats the timeout.
                  state_r <= ST_FAULT;
                  fault_r <= 1'b1;
                  err_r   <= ERR_TIMEOUT;
               end else if (advance_s) begin
                  phase_r <= phase_r + 3'd1;
               end else begin
                  phase_r <= phase_r;
               end
            end
            ST_HALTED: begin
               if (resume) begin
                  state_r <= ST_RUN;
                  phase_r <= PH_5;
               end else begin
                  state_r <= ST_HALTED;
               end
            end
            ST_FAULT: begin
               state_r <= ST_FAULT;
            end
            default: begin
               state_r <= ST_FAULT;
               fault_r <= 1'b1;
            end
         endcase
      end
   end

   assign phase    = phase_r;
   assign sel      = out_s.sel;
   assign rd       = out_s.rd;
   assign ld_ir    = out_s.ld_ir;
   assign inc_pc   = out_s.inc_pc;
   assign halt     = out_s.halt;
   assign ld_ac    = out_s.ld_ac;
   assign data_e   = out_s.data_e;
   assign ld_pc    = out_s.ld_pc;
   assign wr       = out_s.wr;
   assign fault    = fault_r;
   assign err_code = err_r;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer built with OPC_W=4 and MAX_WAIT=4:
// a vector table for whole instructions plus hand sequences for stalls, halt, faults and reset.
module tb_ctrl_sequencer;

   localparam int OPC_W    = 4;
   localparam int MAX_WAIT = 4;

   // Strobe bit masks in the order {sel, rd, ld_ir, inc_pc, halt, ld_ac, data_e, ld_pc, wr}.
   localparam logic [8:0] B_NONE = 9'h000;
   localparam logic [8:0] B_SEL  = 9'h100;
   localparam logic [8:0] B_RD   = 9'h080;
   localparam logic [8:0] B_IR   = 9'h040;
   localparam logic [8:0] B_INC  = 9'h020;
   localparam logic [8:0] B_HALT = 9'h010;
   localparam logic [8:0] B_AC   = 9'h008;
   localparam logic [8:0] B_DE   = 9'h004;
   localparam logic [8:0] B_LPC  = 9'h002;
   localparam logic [8:0] B_WR   = 9'h001;

   logic             clk = 1'b0;
   logic             rst;
   logic [OPC_W-1:0] opcode;
   logic             zero;
   logic             mem_ready;
   logic             resume;
   logic [2:0]       phase;
   logic             sel, rd, ld_ir, inc_pc, halt, ld_ac, data_e, ld_pc, wr;
   logic             fault;
   logic [1:0]       err_code;
   logic [8:0]       strobes;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic       rst;
      logic [3:0] op;
      logic       z;
      logic       mr;
      logic       res;
      logic [2:0] ph;
      logic [8:0] st;
      logic       f;
      logic [1:0] err;
   } vec_t;

   vec_t vecs [35];

   always #5 clk = ~clk;

   assign strobes = {sel, rd, ld_ir, inc_pc, halt, ld_ac, data_e, ld_pc, wr};

   ctrl_sequencer #(
      .OPC_W    (OPC_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .opcode    (opcode),
      .zero      (zero),
      .mem_ready (mem_ready),
      .resume    (resume),
      .phase     (phase),
      .sel       (sel),
      .rd        (rd),
      .ld_ir     (ld_ir),
      .inc_pc    (inc_pc),
      .halt      (halt),
      .ld_ac     (ld_ac),
      .data_e    (data_e),
      .ld_pc     (ld_pc),
      .wr        (wr),
      .fault     (fault),
      .err_code  (err_code)
   );

   function automatic vec_t mk(input logic r, input logic [3:0] op, input logic z, input logic mr,
                               input logic res, input logic [2:0] ph, input logic [8:0] st,
                               input logic f, input logic [1:0] err);
      vec_t v;
      v.rst = r; v.op = op; v.z = z; v.mr = mr; v.res = res;
      v.ph = ph; v.st = st; v.f = f; v.err = err;
      return v;
   endfunction

   task automatic drive(input logic r, input logic [3:0] op, input logic z, input logic mr,
                        input logic res);
      rst = r; opcode = op; zero = z; mem_ready = mr; resume = res;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [2:0] ph, input logic [8:0] st,
                        input logic f, input logic [1:0] e);
      #1;
      n_tests++;
      if (phase !== ph || strobes !== st || fault !== f || err_code !== e) begin
         n_fail++;
         $display("FAIL %s: got phase=%0d strobes=%b fault=%b err=%b, expected phase=%0d strobes=%b fault=%b err=%b",
                  name, phase, strobes, fault, err_code, ph, st, f, e);
      end
   endtask

   task automatic do_reset();
      drive(1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
      step();
   endtask

   task automatic advance(input logic [3:0] op, input int n);
      for (int k = 0; k < n; k++) begin
         drive(1'b0, op, 1'b0, 1'b1, 1'b0);
         step();
      end
   endtask

   initial begin
      drive(1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
      step();
      step();

      // ADD with mem_ready high: one full instruction.
      vecs[0]  = mk(1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 3'd0, B_SEL,             1'b0, 2'b00);
      vecs[1]  = mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 3'd0, B_SEL,             1'b0, 2'b00);
      vecs[2]  = mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 3'd1, B_SEL|B_RD,        1'b0, 2'b00);
      vecs[3]  = mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 3'd2, B_SEL|B_RD|B_IR,   1'b0, 2'b00);
      vecs[4]  = mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 3'd3, B_SEL|B_RD|B_IR,   1'b0, 2'b00);
      vecs[5]  = mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 3'd4, B_INC,             1'b0, 2'b00);
      vecs[6]  = mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 3'd5, B_RD,              1'b0, 2'b00);
      vecs[7]  = mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 3'd6, B_RD,              1'b0, 2'b00);
      vecs[8]  = mk(1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 3'd7, B_RD|B_AC,         1'b0, 2'b00);
      // SKZ with zero=1: skip increment in ph6.
      vecs[9]  = mk(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 3'd0, B_SEL,             1'b0, 2'b00);
      vecs[10] = mk(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 3'd1, B_SEL|B_RD,        1'b0, 2'b00);
      vecs[11] = mk(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 3'd2, B_SEL|B_RD|B_IR,   1'b0, 2'b00);
      vecs[12] = mk(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 3'd3, B_SEL|B_RD|B_IR,   1'b0, 2'b00);
      vecs[13] = mk(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 3'd4, B_INC,             1'b0, 2'b00);
      vecs[14] = mk(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 3'd5, B_NONE,            1'b0, 2'b00);
      vecs[15] = mk(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 3'd6, B_INC,             1'b0, 2'b00);
      vecs[16] = mk(1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 3'd7, B_NONE,            1'b0, 2'b00);
      // SKZ with zero=0: only the ph4 increment.
      vecs[17] = mk(1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd0, B_SEL,             1'b0, 2'b00);
      vecs[18] = mk(1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd1, B_SEL|B_RD,        1'b0, 2'b00);
      vecs[19] = mk(1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd2, B_SEL|B_RD|B_IR,   1'b0, 2'b00);
      vecs[20] = mk(1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd3, B_SEL|B_RD|B_IR,   1'b0, 2'b00);
      vecs[21] = mk(1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd4, B_INC,             1'b0, 2'b00);
      vecs[22] = mk(1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd5, B_NONE,            1'b0, 2'b00);
      vecs[23] = mk(1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd6, B_NONE,            1'b0, 2'b00);
      vecs[24] = mk(1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 3'd7, B_NONE,            1'b0, 2'b00);
      // JMP: mem_ready/resume ignored in non-memory phases, ld_ir held off during a ph2 stall.
      vecs[25] = mk(1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 3'd0, B_SEL,             1'b0, 2'b00);
      vecs[26] = mk(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 3'd1, B_SEL|B_RD,        1'b0, 2'b00);
      vecs[27] = mk(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 3'd2, B_SEL|B_RD,        1'b0, 2'b00);
      vecs[28] = mk(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 3'd2, B_SEL|B_RD|B_IR,   1'b0, 2'b00);
      vecs[29] = mk(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 3'd3, B_SEL|B_RD|B_IR,   1'b0, 2'b00);
      vecs[30] = mk(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 3'd4, B_INC,             1'b0, 2'b00);
      vecs[31] = mk(1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 3'd5, B_NONE,            1'b0, 2'b00);
      vecs[32] = mk(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 3'd6, B_LPC,             1'b0, 2'b00);
      vecs[33] = mk(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 3'd7, B_LPC,             1'b0, 2'b00);
      vecs[34] = mk(1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 3'd0, B_SEL,             1'b0, 2'b00);

      for (int i = 0; i < 35; i++) begin
         drive(vecs[i].rst, vecs[i].op, vecs[i].z, vecs[i].mr, vecs[i].res);
         check($sformatf("vec%0d", i), vecs[i].ph, vecs[i].st, vecs[i].f, vecs[i].err);
         step();
      end

      // STO: three stalled cycles in ph7, ready on the fourth (coincides with timer limit).
      do_reset();
      advance(4'd6, 6);
      drive(1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
      check("sto_ph6", 3'd6, B_DE, 1'b0, 2'b00);
      step();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
         check($sformatf("sto_stall%0d", k), 3'd7, B_DE|B_WR, 1'b0, 2'b00);
         step();
      end
      drive(1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
      check("sto_ready_at_limit", 3'd7, B_DE|B_WR, 1'b0, 2'b00);
      step();
      drive(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
      check("sto_wrap", 3'd0, B_SEL, 1'b0, 2'b00);
      step();

      // HLT: single inc_pc in ph4, frozen for 10 cycles, resume to ph5.
      do_reset();
      advance(4'd0, 4);
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      check("hlt_ph4", 3'd4, B_INC|B_HALT, 1'b0, 2'b00);
      step();
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 4'd0, 1'b0, k[0], 1'b0);
         check($sformatf("halted%0d", k), 3'd4, B_HALT, 1'b0, 2'b00);
         step();
      end
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("halted_resume", 3'd4, B_HALT, 1'b0, 2'b00);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      check("resumed_ph5", 3'd5, B_NONE, 1'b0, 2'b00);
      step();
      drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      check("resumed_ph6", 3'd6, B_NONE, 1'b0, 2'b00);
      step();

      // Bus timeout in ph1 after four stall cycles; resume ignored; rst clears.
      do_reset();
      advance(4'd2, 1);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
         check($sformatf("stall_ph1_%0d", k), 3'd1, B_SEL|B_RD, 1'b0, 2'b00);
         step();
      end
      drive(1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
      check("timeout_fault", 3'd1, B_HALT, 1'b1, 2'b01);
      step();
      drive(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
      check("fault_hold", 3'd1, B_HALT, 1'b1, 2'b01);
      step();
      drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      check("fault_in_rst", 3'd0, B_SEL, 1'b0, 2'b00);
      step();
      drive(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
      check("fault_post_rst", 3'd0, B_SEL, 1'b0, 2'b00);
      step();

      // Illegal opcode 9 faults at ph4 with inc_pc still issued.
      do_reset();
      advance(4'd9, 4);
      drive(1'b0, 4'd9, 1'b0, 1'b1, 1'b0);
      check("ill_ph4", 3'd4, B_INC, 1'b0, 2'b00);
      step();
      drive(1'b0, 4'd9, 1'b0, 1'b1, 1'b1);
      check("ill_fault", 3'd4, B_HALT, 1'b1, 2'b10);
      step();
      drive(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
      check("ill_fault_hold", 3'd4, B_HALT, 1'b1, 2'b10);
      step();

      // Reset in the middle of a ph2 stall.
      do_reset();
      advance(4'd2, 2);
      drive(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
      check("stall_ph2", 3'd2, B_SEL|B_RD, 1'b0, 2'b00);
      step();
      step();
      drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
      check("rst_midstall", 3'd0, B_SEL, 1'b0, 2'b00);
      step();
      drive(1'b0, 4'd2, 1'b0, 1'b1, 1'b0);
      check("rst_midstall_next", 3'd1, B_SEL|B_RD, 1'b0, 2'b00);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
